// File: rtl/mdu_multicycle.sv
// Multi-cycle multiply/divide unit with architectural HI/LO for the EX stage.
// Results land N cycles after launch (N = MULT_CYCLES or DIV_CYCLES); starts while busy are dropped.
module mdu_multicycle #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       mdu_type,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             d_is_mdu,
  output logic             busy,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] rdata
);

  localparam int MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CntW      = $clog2(MaxCycles + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                  state, stateNext;
  logic [CntW-1:0]         cnt;
  logic [WIDTH-1:0]        pHi, pLo;
  logic                    pWr;
  logic                    launch, isMulOp, lastCycle;
  logic [WIDTH-1:0]        resHi, resLo;
  logic                    resWr;
  logic signed [2*WIDTH-1:0] prodS;
  logic [2*WIDTH-1:0]      prodU;
  logic signed [WIDTH-1:0] aS, bS, qS, rS;
  logic [WIDTH-1:0]        divU, qU, rU;
  logic                    divOvf;

  assign busy      = (state == BUSY);
  assign launch    = start & ~busy & (mdu_type >= 4'd1) & (mdu_type <= 4'd4);
  assign isMulOp   = (mdu_type == 4'd1) | (mdu_type == 4'd2);
  assign lastCycle = (cnt == CntW'(1));
  assign stall     = d_is_mdu & (busy | launch);
  assign rdata     = (mdu_type == 4'd5) ? hi : lo;

  // Divisor of zero is replaced by one so the dividers stay defined; the result is discarded anyway.
  always_comb begin
    prodS  = $signed({{WIDTH{op_a[WIDTH-1]}}, op_a}) * $signed({{WIDTH{op_b[WIDTH-1]}}, op_b});
    prodU  = {{WIDTH{1'b0}}, op_a} * {{WIDTH{1'b0}}, op_b};
    divU   = (op_b == '0) ? WIDTH'(1) : op_b;
    aS     = $signed(op_a);
    bS     = $signed(divU);
    divOvf = (op_a == {1'b1, {(WIDTH-1){1'b0}}}) && (op_b == '1);
    qS     = aS / bS;
    rS     = aS % bS;
    qU     = op_a / divU;
    rU     = op_a % divU;
  end

  always_comb begin
    resHi = '0;
    resLo = '0;
    resWr = 1'b1;
    case (mdu_type)
      4'd1: {resHi, resLo} = prodS;
      4'd2: {resHi, resLo} = prodU;
      4'd3: begin
        resWr = (op_b != '0);
        if (divOvf) begin
          resHi = '0;
          resLo = op_a;
        end else begin
          resHi = rS;
          resLo = qS;
        end
      end
      4'd4: begin
        resWr = (op_b != '0);
        resHi = rU;
        resLo = qU;
      end
      default: resWr = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (launch) stateNext = BUSY;
      BUSY:    if (lastCycle) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      pHi <= '0;
      pLo <= '0;
      pWr <= 1'b0;
      hi  <= '0;
      lo  <= '0;
    end else begin
      if (launch) begin
        cnt <= isMulOp ? CntW'(MULT_CYCLES) : CntW'(DIV_CYCLES);
        pHi <= resHi;
        pLo <= resLo;
        pWr <= resWr;
      end else if (busy) begin
        cnt <= cnt - CntW'(1);
        if (lastCycle && pWr) begin
          hi <= pHi;
          lo <= pLo;
        end
      end
      if (start && !busy && mdu_type == 4'd7) hi <= op_a;
      if (start && !busy && mdu_type == 4'd8) lo <= op_a;
    end
  end

endmodule

// File: tb/tb_mdu_multicycle.sv
// Directed-vector bench for mdu_multicycle with hand-computed HI/LO/busy/stall expectations.
module tb_mdu_multicycle;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  mdu_type;
  logic [31:0] op_a, op_b;
  logic        d_is_mdu;
  logic        busy, stall;
  logic [31:0] hi, lo, rdata;

  int nCompared = 0;
  int nMismatch = 0;
  int nBusy;

  mdu_multicycle #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .mdu_type(mdu_type),
    .op_a(op_a), .op_b(op_b), .d_is_mdu(d_is_mdu),
    .busy(busy), .stall(stall), .hi(hi), .lo(lo), .rdata(rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatch++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents an op for one edge, then returns start to idle.
  task automatic issue(input logic [3:0] t, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; mdu_type = t; op_a = a; op_b = b;
    tick();
    start = 1'b0; mdu_type = 4'd0;
  endtask

  task automatic waitIdle(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      tick();
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mdu_type = 4'd0; op_a = '0; op_b = '0; d_is_mdu = 1'b0;
    tick(); tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    reset = 1'b0;

    // 1: signed mult -1 * 2
    issue(4'd1, 32'hFFFFFFFF, 32'h00000002);
    waitIdle(nBusy);
    chk("mult_busy", nBusy, 32'd5);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFFE);

    // 2: unsigned mult, old values held during busy
    issue(4'd2, 32'hFFFFFFFF, 32'h00000002);
    chk("multu_hold_hi", hi, 32'hFFFFFFFF);
    chk("multu_hold_lo", lo, 32'hFFFFFFFE);
    waitIdle(nBusy);
    chk("multu_busy", nBusy, 32'd5);
    chk("multu_hi", hi, 32'h00000001);
    chk("multu_lo", lo, 32'hFFFFFFFE);

    // 3: signed div -7/2, unsigned div 7/2
    issue(4'd3, 32'hFFFFFFF9, 32'h00000002);
    waitIdle(nBusy);
    chk("div_busy", nBusy, 32'd10);
    chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);
    issue(4'd4, 32'd7, 32'd2);
    waitIdle(nBusy);
    chk("divu_lo", lo, 32'd3);
    chk("divu_hi", hi, 32'd1);

    // 4: mthi/mtlo, mfhi/mflo read path, divide by zero leaves HI/LO
    issue(4'd7, 32'h00001234, 32'd0);
    chk("mthi_hi", hi, 32'h00001234);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    issue(4'd8, 32'h00005678, 32'd0);
    chk("mtlo_lo", lo, 32'h00005678);
    mdu_type = 4'd5; #1;
    chk("mfhi_rdata", rdata, 32'h00001234);
    mdu_type = 4'd6; #1;
    chk("mflo_rdata", rdata, 32'h00005678);
    mdu_type = 4'd0;
    issue(4'd4, 32'd99, 32'd0);
    waitIdle(nBusy);
    chk("div0_busy", nBusy, 32'd10);
    chk("div0_hi", hi, 32'h00001234);
    chk("div0_lo", lo, 32'h00005678);

    // 5: stall generation and start ignored while busy
    d_is_mdu = 1'b1; #1;
    chk("stall_idle", {31'd0, stall}, 32'd0);
    start = 1'b1; mdu_type = 4'd1; op_a = 32'd3; op_b = 32'd4; #1;
    chk("stall_launch", {31'd0, stall}, 32'd1);
    tick();
    start = 1'b0; mdu_type = 4'd0;
    chk("stall_busy", {31'd0, stall}, 32'd1);
    start = 1'b1; mdu_type = 4'd8; op_a = 32'hDEADBEEF;
    tick();
    start = 1'b0; mdu_type = 4'd0;
    chk("mtlo_ignored", lo, 32'h00005678);
    waitIdle(nBusy);
    chk("busy_ignore_len", nBusy, 32'd4);
    chk("stall_after", {31'd0, stall}, 32'd0);
    chk("mult34_hi", hi, 32'd0);
    chk("mult34_lo", lo, 32'd12);
    d_is_mdu = 1'b0;

    // mdu_type 9..15 is no-op
    issue(4'd9, 32'd1, 32'd1);
    chk("type9_busy", {31'd0, busy}, 32'd0);

    // 6: reset abandons an op; div overflow case
    issue(4'd1, 32'd5, 32'd5);
    tick(); tick();
    reset = 1'b1;
    tick();
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    chk("rstmid_hi", hi, 32'd0);
    chk("rstmid_lo", lo, 32'd0);
    reset = 1'b0;
    issue(4'd3, 32'h80000000, 32'hFFFFFFFF);
    waitIdle(nBusy);
    chk("divovf_busy", nBusy, 32'd10);
    chk("divovf_lo", lo, 32'h80000000);
    chk("divovf_hi", hi, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
